// File: rtl/mem_write_arbiter.sv
// -----------------------------------------------------------------------------
// mem_write_arbiter
//
// Shares one AXI4 write path (AW/W/B) between NUM_MASTERS accessors.
//   AW : round-robin grant into a single output register. The winning
//        accessor index becomes the ID MSBs: axi_m_awid = {index, awid}.
//   W  : beats are steered from the accessor at the head of a grant FIFO.
//        The FIFO holds granted AWs in grant order and pops on the last
//        beat of each burst.
//   B  : routed back to the accessor named by the axi_m_bid MSBs. The MSBs
//        are stripped before the ID is returned.
//
// Optional feature (macro WARB_MAX_OUTSTANDING_EN): each accessor gets a
// counter of writes that have been granted but not yet answered. An accessor
// whose counter has reached MAX_OUTSTANDING is left out of arbitration.
//
// Ports (accessor buses are flattened; accessor i owns slice i):
//   aclk, aresetn             clock; synchronous active-low reset
//   axi_s_aw*                 accessor AW channels (awready is a grant pulse)
//   axi_s_w*                  accessor W channels
//   axi_s_b*                  accessor B channels
//   axi_m_aw*                 registered, arbitrated AW towards memory
//   axi_m_w*                  steered W beat towards memory
//   axi_m_b*                  B response from memory
// -----------------------------------------------------------------------------
module mem_write_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int AXI_ID_WIDTH    = 5,
  parameter int AXI_ADDR_WIDTH  = 31,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int WFIFO_DEPTH     = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]         axi_s_awid,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]       axi_s_awaddr,
  input  logic [NUM_MASTERS*8-1:0]                    axi_s_awlen,
  input  logic [NUM_MASTERS*3-1:0]                    axi_s_awsize,
  input  logic [NUM_MASTERS*2-1:0]                    axi_s_awburst,
  input  logic [NUM_MASTERS-1:0]                      axi_s_awvalid,
  output logic [NUM_MASTERS-1:0]                      axi_s_awready,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]       axi_s_wdata,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0]     axi_s_wstrb,
  input  logic [NUM_MASTERS-1:0]                      axi_s_wlast,
  input  logic [NUM_MASTERS-1:0]                      axi_s_wvalid,
  output logic [NUM_MASTERS-1:0]                      axi_s_wready,
  output logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]         axi_s_bid,
  output logic [NUM_MASTERS*2-1:0]                    axi_s_bresp,
  output logic [NUM_MASTERS-1:0]                      axi_s_bvalid,
  input  logic [NUM_MASTERS-1:0]                      axi_s_bready,
  output logic [AXI_ID_WIDTH+$clog2(NUM_MASTERS)-1:0] axi_m_awid,
  output logic [AXI_ADDR_WIDTH-1:0]                   axi_m_awaddr,
  output logic [7:0]                                  axi_m_awlen,
  output logic [2:0]                                  axi_m_awsize,
  output logic [1:0]                                  axi_m_awburst,
  output logic                                        axi_m_awvalid,
  input  logic                                        axi_m_awready,
  output logic [AXI_DATA_WIDTH-1:0]                   axi_m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]                 axi_m_wstrb,
  output logic                                        axi_m_wlast,
  output logic                                        axi_m_wvalid,
  input  logic                                        axi_m_wready,
  input  logic [AXI_ID_WIDTH+$clog2(NUM_MASTERS)-1:0] axi_m_bid,
  input  logic [1:0]                                  axi_m_bresp,
  input  logic                                        axi_m_bvalid,
  output logic                                        axi_m_bready
);

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int OID_W  = AXI_ID_WIDTH + IDX_W;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(WFIFO_DEPTH);
  localparam int CNT_W  = $clog2(WFIFO_DEPTH + 1);

  if (NUM_MASTERS < 2 || (NUM_MASTERS & (NUM_MASTERS - 1)) != 0 ||
      WFIFO_DEPTH < 2 || (WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0 ||
      MAX_OUTSTANDING < 1) begin : g_bad_config
    $error("mem_write_arbiter: unsupported parameter set");
  end

  // Arbitration state and grant decision
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       scan_idx;
  logic                   found;
  logic                   load;
  logic [NUM_MASTERS-1:0] cand;
  logic [NUM_MASTERS-1:0] below_limit;

  // Grant FIFO
  logic [IDX_W-1:0] fifo_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head;

  // B routing
  logic [IDX_W-1:0] b_idx;
  logic             b_hs;

  assign fifo_full  = (fifo_cnt == CNT_W'(WFIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Fullness uses the registered occupancy only, so a pop in the same cycle
  // never frees a slot for a push.
  assign cand = axi_s_awvalid & below_limit & {NUM_MASTERS{!fifo_full}};

  // NOTE: every variable written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant    = '0;
    scan_idx = '0;
    found    = 1'b0;
    // Scan starts one past the last grant and wraps; the final step lands on
    // rr_ptr itself, so a lone requester can win back-to-back.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = rr_ptr + IDX_W'(i);
      if (!found && cand[scan_idx]) begin
        grant = scan_idx;
        found = 1'b1;
      end
    end
  end

  // The output register accepts a new AW when it is empty or draining now.
  assign load = aresetn && found && (!axi_m_awvalid || axi_m_awready);
  assign push = load;

  always_comb begin
    axi_s_awready = '0;
    if (load) begin
      axi_s_awready[grant] = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr        <= IDX_W'(NUM_MASTERS - 1);
      axi_m_awvalid <= 1'b0;
      axi_m_awid    <= '0;
      axi_m_awaddr  <= '0;
      axi_m_awlen   <= '0;
      axi_m_awsize  <= '0;
      axi_m_awburst <= '0;
    end else if (load) begin
      rr_ptr        <= grant;
      axi_m_awvalid <= 1'b1;
      axi_m_awid    <= {grant, axi_s_awid[grant*AXI_ID_WIDTH +: AXI_ID_WIDTH]};
      axi_m_awaddr  <= axi_s_awaddr[grant*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      axi_m_awlen   <= axi_s_awlen[grant*8 +: 8];
      axi_m_awsize  <= axi_s_awsize[grant*3 +: 3];
      axi_m_awburst <= axi_s_awburst[grant*2 +: 2];
    end else if (axi_m_awready) begin
      axi_m_awvalid <= 1'b0;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and the
  // occupancy count are, and no entry is read before it has been written.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= grant;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  // W steering from the FIFO head. Beats may arrive before memory has taken
  // the matching AW, so W is not gated by the AW register.
  always_comb begin
    head         = fifo_mem[rd_ptr];
    axi_m_wdata  = axi_s_wdata[head*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    axi_m_wstrb  = axi_s_wstrb[head*STRB_W +: STRB_W];
    axi_m_wlast  = axi_s_wlast[head];
    axi_m_wvalid = aresetn && !fifo_empty && axi_s_wvalid[head];
    axi_s_wready = '0;
    if (aresetn && !fifo_empty) begin
      axi_s_wready[head] = axi_m_wready;
    end
  end

  assign pop = axi_m_wvalid && axi_m_wready && axi_m_wlast;

  // B routing: the ID MSBs select the accessor. ID and response are broadcast
  // to every slice; only the selected accessor sees bvalid.
  assign b_idx       = axi_m_bid[OID_W-1 -: IDX_W];
  assign axi_s_bid   = {NUM_MASTERS{axi_m_bid[AXI_ID_WIDTH-1:0]}};
  assign axi_s_bresp = {NUM_MASTERS{axi_m_bresp}};

  always_comb begin
    axi_s_bvalid = '0;
    axi_m_bready = aresetn && axi_s_bready[b_idx];
    if (aresetn) begin
      axi_s_bvalid[b_idx] = axi_m_bvalid;
    end
  end

  assign b_hs = axi_m_bvalid && axi_m_bready;

`ifdef WARB_MAX_OUTSTANDING_EN
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [OCNT_W-1:0]      ocnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] ocnt_inc;
  logic [NUM_MASTERS-1:0] ocnt_dec;

  always_comb begin
    ocnt_inc    = '0;
    ocnt_dec    = '0;
    below_limit = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      below_limit[i] = (ocnt[i] != OCNT_W'(MAX_OUTSTANDING));
      ocnt_inc[i]    = load && (grant == IDX_W'(i));
      // A response for an accessor with nothing outstanding is ignored so
      // the counter cannot wrap below zero.
      ocnt_dec[i]    = b_hs && (b_idx == IDX_W'(i)) && (ocnt[i] != '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        ocnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (ocnt_inc[i] && !ocnt_dec[i]) begin
          ocnt[i] <= ocnt[i] + 1'b1;
        end else if (ocnt_dec[i] && !ocnt_inc[i]) begin
          ocnt[i] <= ocnt[i] - 1'b1;
        end
      end
    end
  end
`else
  assign below_limit = '1;
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_write_arbiter
//
// Directed bench for mem_write_arbiter with the default sizing (4 accessors,
// 5-bit accessor IDs, 8-entry grant FIFO) and MAX_OUTSTANDING = 2. Inputs
// change on the falling edge; outputs are sampled on the falling edge or 1ns
// after an input change, well away from the rising edge. The outstanding-
// limit scenario is compiled in when WARB_MAX_OUTSTANDING_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_write_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 5;
  localparam int AW   = 31;
  localparam int DW   = 128;
  localparam int SW   = DW / 8;
  localparam int IDXW = 2;
  localparam int OIDW = IDW + IDXW;

  logic              aclk;
  logic              aresetn;
  logic [N*IDW-1:0]  axi_s_awid;
  logic [N*AW-1:0]   axi_s_awaddr;
  logic [N*8-1:0]    axi_s_awlen;
  logic [N*3-1:0]    axi_s_awsize;
  logic [N*2-1:0]    axi_s_awburst;
  logic [N-1:0]      axi_s_awvalid;
  logic [N-1:0]      axi_s_awready;
  logic [N*DW-1:0]   axi_s_wdata;
  logic [N*SW-1:0]   axi_s_wstrb;
  logic [N-1:0]      axi_s_wlast;
  logic [N-1:0]      axi_s_wvalid;
  logic [N-1:0]      axi_s_wready;
  logic [N*IDW-1:0]  axi_s_bid;
  logic [N*2-1:0]    axi_s_bresp;
  logic [N-1:0]      axi_s_bvalid;
  logic [N-1:0]      axi_s_bready;
  logic [OIDW-1:0]   axi_m_awid;
  logic [AW-1:0]     axi_m_awaddr;
  logic [7:0]        axi_m_awlen;
  logic [2:0]        axi_m_awsize;
  logic [1:0]        axi_m_awburst;
  logic              axi_m_awvalid;
  logic              axi_m_awready;
  logic [DW-1:0]     axi_m_wdata;
  logic [SW-1:0]     axi_m_wstrb;
  logic              axi_m_wlast;
  logic              axi_m_wvalid;
  logic              axi_m_wready;
  logic [OIDW-1:0]   axi_m_bid;
  logic [1:0]        axi_m_bresp;
  logic              axi_m_bvalid;
  logic              axi_m_bready;

  int vectors;
  int miscompares;

  mem_write_arbiter #(
    .NUM_MASTERS    (N),
    .AXI_ID_WIDTH   (IDW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .WFIFO_DEPTH    (8),
    .MAX_OUTSTANDING(2)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .axi_s_awid    (axi_s_awid),
    .axi_s_awaddr  (axi_s_awaddr),
    .axi_s_awlen   (axi_s_awlen),
    .axi_s_awsize  (axi_s_awsize),
    .axi_s_awburst (axi_s_awburst),
    .axi_s_awvalid (axi_s_awvalid),
    .axi_s_awready (axi_s_awready),
    .axi_s_wdata   (axi_s_wdata),
    .axi_s_wstrb   (axi_s_wstrb),
    .axi_s_wlast   (axi_s_wlast),
    .axi_s_wvalid  (axi_s_wvalid),
    .axi_s_wready  (axi_s_wready),
    .axi_s_bid     (axi_s_bid),
    .axi_s_bresp   (axi_s_bresp),
    .axi_s_bvalid  (axi_s_bvalid),
    .axi_s_bready  (axi_s_bready),
    .axi_m_awid    (axi_m_awid),
    .axi_m_awaddr  (axi_m_awaddr),
    .axi_m_awlen   (axi_m_awlen),
    .axi_m_awsize  (axi_m_awsize),
    .axi_m_awburst (axi_m_awburst),
    .axi_m_awvalid (axi_m_awvalid),
    .axi_m_awready (axi_m_awready),
    .axi_m_wdata   (axi_m_wdata),
    .axi_m_wstrb   (axi_m_wstrb),
    .axi_m_wlast   (axi_m_wlast),
    .axi_m_wvalid  (axi_m_wvalid),
    .axi_m_wready  (axi_m_wready),
    .axi_m_bid     (axi_m_bid),
    .axi_m_bresp   (axi_m_bresp),
    .axi_m_bvalid  (axi_m_bvalid),
    .axi_m_bready  (axi_m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1);
  end

  task automatic clear_inputs();
    axi_s_awid    = '0;
    axi_s_awaddr  = '0;
    axi_s_awlen   = '0;
    axi_s_awsize  = '0;
    axi_s_awburst = '0;
    axi_s_awvalid = '0;
    axi_s_wdata   = '0;
    axi_s_wstrb   = '0;
    axi_s_wlast   = '0;
    axi_s_wvalid  = '0;
    axi_s_bready  = '0;
    axi_m_awready = 1'b0;
    axi_m_wready  = 1'b0;
    axi_m_bid     = '0;
    axi_m_bresp   = '0;
    axi_m_bvalid  = 1'b0;
  endtask

  // Leaves the bench on a falling edge with reset just released.
  task automatic do_reset();
    clear_inputs();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    aresetn       = 1'b0;
    axi_s_awvalid = 4'hF;
    axi_s_wvalid  = 4'hF;
    axi_s_bready  = 4'hF;
    axi_m_awready = 1'b1;
    axi_m_wready  = 1'b1;
    axi_m_bvalid  = 1'b1;
    repeat (2) @(negedge aclk);
    vectors++;
    if (axi_m_awvalid !== 1'b0 || axi_s_awready !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_aw: m_awvalid=%b s_awready=%b, want 0/0000", axi_m_awvalid, axi_s_awready);
    end
    vectors++;
    if (axi_m_wvalid !== 1'b0 || axi_s_wready !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_w: m_wvalid=%b s_wready=%b, want 0/0000", axi_m_wvalid, axi_s_wready);
    end
    vectors++;
    if (axi_s_bvalid !== 4'h0 || axi_m_bready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: s_bvalid=%b m_bready=%b, want 0000/0", axi_s_bvalid, axi_m_bready);
    end
    clear_inputs();
    aresetn = 1'b1;
  endtask

  // All four accessors request every cycle; grants rotate starting at 0.
  task automatic test_round_robin();
    int         exp_g [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_rdy;
    logic [6:0] exp_id;
    do_reset();
    for (int i = 0; i < N; i++) begin
      axi_s_awid[i*IDW +: IDW] = IDW'(i + 8);
    end
    axi_s_awvalid = 4'hF;
    axi_m_awready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = 4'(1 << exp_g[k]);
      vectors++;
      if (axi_s_awready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: s_awready=%b, want %b", k, axi_s_awready, exp_rdy);
      end
      @(negedge aclk);
      exp_id = {IDXW'(exp_g[k]), IDW'(exp_g[k] + 8)};
      vectors++;
      if (axi_m_awvalid !== 1'b1 || axi_m_awid !== exp_id) begin
        miscompares++;
        $display("FAIL rr_awid[%0d]: awvalid=%b awid=%h, want 1/%h", k, axi_m_awvalid, axi_m_awid, exp_id);
      end
    end
    clear_inputs();
  endtask

  // AW from accessor 2 is registered with its index in the ID MSBs and held
  // while memory stalls; a later request waits for the register to drain.
  task automatic test_aw_payload();
    do_reset();
    axi_s_awid[2*IDW +: IDW]  = 5'h03;
    axi_s_awaddr[2*AW +: AW]  = 31'h100;
    axi_s_awlen[2*8 +: 8]     = 8'h07;
    axi_s_awsize[2*3 +: 3]    = 3'd4;
    axi_s_awburst[2*2 +: 2]   = 2'b01;
    axi_s_awvalid             = 4'b0100;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0100) begin
      miscompares++;
      $display("FAIL aw_grant2: s_awready=%b, want 0100", axi_s_awready);
    end
    @(negedge aclk);
    axi_s_awvalid            = 4'b0001;
    axi_s_awid[0 +: IDW]     = 5'h1A;
    axi_s_awaddr[0 +: AW]    = 31'h200;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0000) begin
      miscompares++;
      $display("FAIL aw_stall_grant: s_awready=%b, want 0000", axi_s_awready);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (axi_m_awvalid !== 1'b1 || axi_m_awid !== 7'h43 || axi_m_awaddr !== 31'h100 ||
          axi_m_awlen !== 8'h07 || axi_m_awsize !== 3'd4 || axi_m_awburst !== 2'b01) begin
        miscompares++;
        $display("FAIL aw_hold[%0d]: v=%b id=%h addr=%h len=%h size=%0d burst=%b, want 1/43/100/07/4/01",
                 c, axi_m_awvalid, axi_m_awid, axi_m_awaddr, axi_m_awlen, axi_m_awsize, axi_m_awburst);
      end
      @(negedge aclk);
    end
    axi_m_awready = 1'b1;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0001) begin
      miscompares++;
      $display("FAIL aw_drain_grant: s_awready=%b, want 0001", axi_s_awready);
    end
    @(negedge aclk);
    axi_s_awvalid = '0;
    vectors++;
    if (axi_m_awvalid !== 1'b1 || axi_m_awid !== 7'h1A || axi_m_awaddr !== 31'h200) begin
      miscompares++;
      $display("FAIL aw_reload: v=%b id=%h addr=%h, want 1/1a/200", axi_m_awvalid, axi_m_awid, axi_m_awaddr);
    end
    clear_inputs();
  endtask

  // Grants 1 then 3; accessor 3 offers W early but must wait for 1's burst.
  task automatic test_w_order();
    logic [DW-1:0] beat;
    do_reset();
    axi_m_awready         = 1'b1;
    axi_s_awlen[1*8 +: 8] = 8'd3;
    axi_s_awlen[3*8 +: 8] = 8'd3;
    axi_s_awvalid         = 4'b0010;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0010) begin
      miscompares++;
      $display("FAIL w_aw1: s_awready=%b, want 0010", axi_s_awready);
    end
    @(negedge aclk);
    axi_s_awvalid = 4'b1000;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b1000) begin
      miscompares++;
      $display("FAIL w_aw3: s_awready=%b, want 1000", axi_s_awready);
    end
    @(negedge aclk);
    axi_s_awvalid             = '0;
    axi_m_wready              = 1'b1;
    axi_s_wdata[3*DW +: DW]   = {4{32'hD3D3_0003}};
    axi_s_wvalid              = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (axi_m_wvalid !== 1'b0 || axi_s_wready !== 4'b0010) begin
        miscompares++;
        $display("FAIL w_early3[%0d]: m_wvalid=%b s_wready=%b, want 0/0010", c, axi_m_wvalid, axi_s_wready);
      end
      @(negedge aclk);
    end
    axi_s_wvalid           = 4'b1010;
    axi_s_wstrb[1*SW +: SW] = 16'h0F0F;
    for (int b = 0; b < 4; b++) begin
      beat                    = {96'h0, 32'hA100_0000 + 32'(b)};
      axi_s_wdata[1*DW +: DW] = beat;
      axi_s_wlast             = (b == 3) ? 4'b0010 : 4'b0000;
      #1;
      vectors++;
      if (axi_m_wvalid !== 1'b1 || axi_m_wdata !== beat || axi_m_wstrb !== 16'h0F0F ||
          axi_m_wlast !== (b == 3) || axi_s_wready !== 4'b0010) begin
        miscompares++;
        $display("FAIL w_beat1[%0d]: v=%b data=%h strb=%h last=%b rdy=%b, want 1/%h/0f0f/%b/0010",
                 b, axi_m_wvalid, axi_m_wdata, axi_m_wstrb, axi_m_wlast, axi_s_wready, beat, (b == 3));
      end
      @(negedge aclk);
    end
    axi_s_wvalid = 4'b1000;
    axi_s_wlast  = 4'b0000;
    #1;
    vectors++;
    if (axi_m_wvalid !== 1'b1 || axi_m_wdata !== {4{32'hD3D3_0003}} || axi_s_wready !== 4'b1000) begin
      miscompares++;
      $display("FAIL w_head3: v=%b data=%h rdy=%b, want 1/d3d30003x4/1000", axi_m_wvalid, axi_m_wdata, axi_s_wready);
    end
    @(negedge aclk);
    clear_inputs();
  endtask

  // Eight grants fill the FIFO; a pop in the full cycle does not let a push
  // through, the next cycle does.
  task automatic test_fifo_full();
    do_reset();
    axi_m_awready = 1'b1;
    axi_s_awvalid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      vectors++;
      if (axi_s_awready !== 4'b0001) begin
        miscompares++;
        $display("FAIL fill_grant[%0d]: s_awready=%b, want 0001", k, axi_s_awready);
      end
      @(negedge aclk);
    end
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0000) begin
      miscompares++;
      $display("FAIL full_stall: s_awready=%b, want 0000", axi_s_awready);
    end
    @(negedge aclk);
    axi_m_wready = 1'b1;
    axi_s_wvalid = 4'b0001;
    axi_s_wlast  = 4'b0001;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0000 || axi_m_wvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop_same_cycle: s_awready=%b m_wvalid=%b, want 0000/1", axi_s_awready, axi_m_wvalid);
    end
    @(negedge aclk);
    axi_s_wvalid = '0;
    axi_s_wlast  = '0;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0001) begin
      miscompares++;
      $display("FAIL after_pop_grant: s_awready=%b, want 0001", axi_s_awready);
    end
    @(negedge aclk);
    clear_inputs();
  endtask

  task automatic test_b_route();
    do_reset();
    axi_m_bid    = 7'h23;
    axi_m_bresp  = 2'b10;
    axi_m_bvalid = 1'b1;
    axi_s_bready = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (axi_s_bvalid !== 4'b0010 || axi_s_bid[1*IDW +: IDW] !== 5'h03 ||
          axi_s_bresp[1*2 +: 2] !== 2'b10 || axi_m_bready !== 1'b0) begin
        miscompares++;
        $display("FAIL b_wait[%0d]: bvalid=%b bid=%h bresp=%b m_bready=%b, want 0010/03/10/0",
                 c, axi_s_bvalid, axi_s_bid[1*IDW +: IDW], axi_s_bresp[1*2 +: 2], axi_m_bready);
      end
      @(negedge aclk);
    end
    axi_s_bready = 4'b0010;
    #1;
    vectors++;
    if (axi_m_bready !== 1'b1 || axi_s_bvalid !== 4'b0010) begin
      miscompares++;
      $display("FAIL b_ready: m_bready=%b bvalid=%b, want 1/0010", axi_m_bready, axi_s_bvalid);
    end
    @(negedge aclk);
    clear_inputs();
  endtask

  // Reset in the middle of a W burst clears everything; the remaining beats
  // of that burst are not forwarded afterwards.
  task automatic test_reset_mid_burst();
    do_reset();
    axi_s_awlen[0 +: 8] = 8'd3;
    axi_s_awvalid       = 4'b0001;
    @(negedge aclk);
    axi_s_awvalid = '0;
    axi_m_wready  = 1'b1;
    axi_s_wvalid  = 4'b0001;
    #1;
    vectors++;
    if (axi_m_wvalid !== 1'b1 || axi_m_awvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_burst_active: m_wvalid=%b m_awvalid=%b, want 1/1", axi_m_wvalid, axi_m_awvalid);
    end
    repeat (2) @(negedge aclk);
    aresetn       = 1'b0;
    axi_s_awvalid = 4'b0100;
    axi_m_bid     = 7'h40;
    axi_m_bvalid  = 1'b1;
    axi_s_bready  = 4'hF;
    @(negedge aclk);
    vectors++;
    if (axi_m_awvalid !== 1'b0 || axi_s_awready !== 4'h0 || axi_m_wvalid !== 1'b0 ||
        axi_s_wready !== 4'h0 || axi_s_bvalid !== 4'h0 || axi_m_bready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_burst_reset: awv=%b awr=%b wv=%b wr=%b bv=%b br=%b, want all 0",
               axi_m_awvalid, axi_s_awready, axi_m_wvalid, axi_s_wready, axi_s_bvalid, axi_m_bready);
    end
    axi_s_awvalid = '0;
    axi_m_bvalid  = 1'b0;
    aresetn       = 1'b1;
    @(negedge aclk);
    vectors++;
    if (axi_m_wvalid !== 1'b0 || axi_s_wready !== 4'h0 || axi_m_awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_no_replay: wv=%b wr=%b awv=%b, want 0/0000/0",
               axi_m_wvalid, axi_s_wready, axi_m_awvalid);
    end
    clear_inputs();
  endtask

`ifdef WARB_MAX_OUTSTANDING_EN
  // Limit 2: accessor 0 blocks after two grants until a B returns. A B for
  // accessor 1 with nothing outstanding must not wrap its counter.
  task automatic test_max_outstanding();
    logic [3:0] exp_rdy;
    do_reset();
    axi_m_awready = 1'b1;
    axi_s_awvalid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_rdy = (k < 2) ? 4'b0001 : 4'b0000;
      vectors++;
      if (axi_s_awready !== exp_rdy) begin
        miscompares++;
        $display("FAIL limit_grant[%0d]: s_awready=%b, want %b", k, axi_s_awready, exp_rdy);
      end
      @(negedge aclk);
    end
    axi_m_bid    = 7'h00;
    axi_m_bvalid = 1'b1;
    axi_s_bready = 4'b0001;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0000 || axi_m_bready !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_b_cycle: s_awready=%b m_bready=%b, want 0000/1", axi_s_awready, axi_m_bready);
    end
    @(negedge aclk);
    axi_m_bvalid = 1'b0;
    axi_s_bready = '0;
    #1;
    vectors++;
    if (axi_s_awready !== 4'b0001) begin
      miscompares++;
      $display("FAIL limit_release: s_awready=%b, want 0001", axi_s_awready);
    end
    do_reset();
    axi_m_awready = 1'b1;
    axi_m_bid     = 7'h20;
    axi_m_bvalid  = 1'b1;
    axi_s_bready  = 4'b0010;
    @(negedge aclk);
    axi_m_bvalid  = 1'b0;
    axi_s_bready  = '0;
    axi_s_awvalid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_rdy = (k < 2) ? 4'b0010 : 4'b0000;
      vectors++;
      if (axi_s_awready !== exp_rdy) begin
        miscompares++;
        $display("FAIL no_wrap_grant[%0d]: s_awready=%b, want %b", k, axi_s_awready, exp_rdy);
      end
      @(negedge aclk);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    aresetn     = 1'b0;
    clear_inputs();
    @(negedge aclk);
    test_reset();
    test_round_robin();
    test_aw_payload();
    test_w_order();
    test_fifo_full();
    test_b_route();
    test_reset_mid_burst();
`ifdef WARB_MAX_OUTSTANDING_EN
    test_max_outstanding();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
